// File: rtl/spi_resp_regs_if.sv
// SPI pin bundle between the HPS SPI master and the fabric responder.
interface spi_resp_regs_if;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_ss_n;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk, spi_mosi, spi_ss_n,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_ss_n,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_resp_regs.sv
// SPI mode-0 responder register file, oversampled in clk_clk; status byte at 7'h7F.
// Define SPI_RESP_BURST_EN for auto-increment bursts; otherwise only the first data byte is acted on.
module spi_resp_regs #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  spi_resp_regs_if.slave       spi,
  input  logic [7:0]           status_in,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic [8*DEPTH-1:0]   regs_flat
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [6:0]  DEPTH7 = 7'(DEPTH);
`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t      state, state_nxt;
  logic [1:0]  sclk_s;
  logic [2:0]  mosi_s;
  logic [1:0]  ss_s;
  logic        sclk_d, rise, fall;
  logic [1:0]  warm;
  logic        armed;
  logic        sel;
  logic        mosi_bit;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  byte_in;
  logic [7:0]  tx;
  logic        miso;
  logic        wr_en;
  logic        first;
  logic [6:0]  cur_addr, nxt_addr, rd_addr;
  logic [7:0]  rd_byte;
  logic        byte_done, do_write;
  logic [7:0]  regs [DEPTH];

  assign sel      = ~ss_s[1];
  assign mosi_bit = mosi_s[2];
  assign byte_in  = {shreg, mosi_bit};
  assign spi.spi_miso    = miso;
  assign spi.spi_miso_oe = sel;

  // armed only once a deselect has been seen with settled synchronizers,
  // so a frame already in flight at reset release is ignored
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_s <= '0;
      mosi_s <= '0;
      ss_s   <= '1;
      sclk_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      warm   <= '0;
      armed  <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], spi.spi_sclk};
      mosi_s <= {mosi_s[1:0], spi.spi_mosi};
      ss_s   <= {ss_s[0], spi.spi_ss_n};
      sclk_d <= sclk_s[1];
      rise   <= sclk_s[1] & ~sclk_d;
      fall   <= ~sclk_s[1] & sclk_d;
      warm   <= {warm[0], 1'b1};
      if (warm[1] && !sel)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_done = rise && sel && (state != IDLE) && (bit_cnt == 3'd7);
    do_write  = byte_done && (state == DATA) && wr_en && (BURST || first)
                && (cur_addr < DEPTH7);
    case (state)
      IDLE:    if (sel && armed) state_nxt = CMD;
      CMD:     if (!sel) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (!sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in-range addresses wrap within the register file; out-of-range ones hold
  always_comb begin
    nxt_addr = cur_addr;
    if (cur_addr < DEPTH7) begin
      nxt_addr = '0;
      nxt_addr[AW-1:0] = cur_addr[AW-1:0] + AW'(1);
    end
    rd_addr = (state == CMD) ? byte_in[6:0] : nxt_addr;
    if (rd_addr == 7'h7F)       rd_byte = status_in;
    else if (rd_addr < DEPTH7)  rd_byte = regs[rd_addr[AW-1:0]];
    else                        rd_byte = '0;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      miso      <= 1'b0;
      wr_en     <= 1'b0;
      first     <= 1'b0;
      cur_addr  <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int unsigned k = 0; k < DEPTH; k++)
        regs[k] <= RESET_VAL;
    end else begin
      wr_strobe <= 1'b0;
      if (state == IDLE || !sel) begin
        bit_cnt <= '0;
        tx      <= '0;
        miso    <= 1'b0;
      end else begin
        if (rise) begin
          shreg   <= byte_in[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (fall) begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
        if (byte_done) begin
          if (state == CMD) begin
            wr_en    <= byte_in[7];
            cur_addr <= byte_in[6:0];
            first    <= 1'b1;
            tx       <= rd_byte;
          end else begin
            first    <= 1'b0;
            cur_addr <= nxt_addr;
            tx       <= BURST ? rd_byte : 8'h00;
            if (do_write) begin
              regs[cur_addr[AW-1:0]] <= byte_in;
              wr_strobe <= 1'b1;
              wr_addr   <= cur_addr;
              wr_data   <= byte_in;
            end
          end
        end
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned k = 0; k < DEPTH; k++)
      regs_flat[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_spi_resp_regs.sv
// Self-checking bench for spi_resp_regs: directed frames plus random frames against a frame-level model.
module tb_spi_resp_regs;
  localparam int DEPTH = 16;
`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          status;
  logic                wr_strobe;
  logic [6:0]          wr_addr;
  logic [7:0]          wr_data;
  logic [8*DEPTH-1:0]  regs_flat;

  spi_resp_regs_if bus ();

  spi_resp_regs #(.DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .spi         (bus),
    .status_in   (status),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .regs_flat   (regs_flat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [22:0] stb_q[$];
  int          part_bits = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (wr_strobe)
      stb_q.push_back({wr_addr, wr_data, regs_flat[8*wr_addr +: 8]});

  function automatic logic [7:0] m_read(input int ad);
    if (ad == 127)  return status;
    if (ad < DEPTH) return mem[ad];
    return 8'h00;
  endfunction

  // one SCLK period at clk/8: MISO sampled just before the rising edge
  task automatic spi_bit(input logic b, output logic m);
    bus.spi_mosi = b;
    repeat (4) @(negedge clk);
    m = bus.spi_miso;
    bus.spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], m);
      r[i] = m;
    end
  endtask

  task automatic send_frame(input string name);
    logic [7:0] r;
    logic m;
    rx_q.delete();
    bus.spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    foreach (tx_q[j]) begin
      send_byte(tx_q[j], r);
      rx_q.push_back(r);
    end
    for (int i = 0; i < part_bits; i++)
      spi_bit(1'($urandom_range(0, 1)), m);
    check({name, "_oe_sel"}, 32'(bus.spi_miso_oe), 32'd1);
    repeat (4) @(negedge clk);
    bus.spi_ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check({name, "_oe_idle"}, 32'(bus.spi_miso_oe), 32'd0);
  endtask

  task automatic check_regs(input string name);
    for (int r = 0; r < DEPTH; r++)
      check($sformatf("%s_reg%0d", name, r), 32'(regs_flat[8*r +: 8]), 32'(mem[r]));
  endtask

  task automatic run_frame(input string name);
    logic [7:0]  exp_m[$];
    logic [22:0] exp_s[$];
    int a;
    bit w;
    a = int'(tx_q[0][6:0]);
    w = tx_q[0][7];
    exp_m.push_back(8'h00);
    for (int n = 1; n < tx_q.size(); n++) begin
      int  idx;
      int  ad;
      bit  act;
      idx = n - 1;
      ad  = (a >= DEPTH) ? a : (a + idx) % DEPTH;
      act = BURST || (idx == 0);
      exp_m.push_back(act ? m_read(ad) : 8'h00);
      if (w && act && ad < DEPTH) begin
        mem[ad] = tx_q[n];
        exp_s.push_back({7'(ad), tx_q[n], tx_q[n]});
      end
    end
    stb_q.delete();
    send_frame(name);
    for (int n = 0; n < exp_m.size(); n++)
      check($sformatf("%s_miso%0d", name, n), 32'(rx_q[n]), 32'(exp_m[n]));
    check({name, "_stb_cnt"}, 32'(stb_q.size()), 32'(exp_s.size()));
    for (int k = 0; k < exp_s.size() && k < stb_q.size(); k++)
      check($sformatf("%s_stb%0d", name, k), 32'(stb_q[k]), 32'(exp_s[k]));
    check_regs(name);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic m;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_ss_n = 1'b1;
    status = 8'h00;
    rst = 1'b1;
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_regs", 32'(regs_flat != '0), 32'd0);
    check("rst_miso", 32'(bus.spi_miso), 32'd0);
    check("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
    check("rst_stb", 32'(wr_strobe), 32'd0);
    check("rst_waddr", 32'(wr_addr), 32'd0);
    check("rst_wdata", 32'(wr_data), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    tx_q = '{8'h83, 8'hA5};          run_frame("wr3");
    tx_q = '{8'h03, 8'h00};          run_frame("rd3");
    status = 8'h5C;
    tx_q = '{8'h7F, 8'h00};          run_frame("rd7f");
    tx_q = '{8'h20, 8'h00};          run_frame("rd20");
    tx_q = '{8'h8E, 8'h11, 8'h22, 8'h33}; run_frame("burst");
    tx_q = '{8'h81}; part_bits = 5;  run_frame("abort");
    part_bits = 0;
    tx_q = '{8'h81, 8'h3C};          run_frame("post_abort");

    // reset pulse in the middle of a write data byte
    stb_q.delete();
    bus.spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    send_byte(8'h82, r);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'h00;
    check_regs("midrst");
    check("midrst_miso", 32'(bus.spi_miso), 32'd0);
    check("midrst_oe", 32'(bus.spi_miso_oe), 32'd0);
    check("midrst_stb", 32'(wr_strobe), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    send_byte(8'hFF, r);
    repeat (4) @(negedge clk);
    bus.spi_ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_stb_cnt", 32'(stb_q.size()), 32'd0);
    check_regs("midrst_after");
    tx_q = '{8'h82, 8'hFF};          run_frame("post_rst");

    for (int f = 0; f < 25; f++) begin
      int sel;
      int nd;
      logic [6:0] ad;
      status = 8'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      ad = 7'h7F;
      else if (sel == 1) ad = 7'($urandom_range(0, 127));
      else               ad = 7'($urandom_range(0, DEPTH - 1));
      tx_q.delete();
      tx_q.push_back({1'($urandom_range(0, 1)), ad});
      nd = $urandom_range(1, 4);
      for (int n = 0; n < nd; n++) tx_q.push_back(8'($urandom));
      part_bits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      run_frame($sformatf("rnd%0d", f));
    end
    part_bits = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
